// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci sequence controller.
// Optional saturating overflow behaviour is selected with FIB_SEQ_CTRL_SATURATE_EN.
package fib_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int SEQ_SEED  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_step.sv
// Fibonacci datapath: cur/prev term registers and a WIDTH+1 bit adder.
// FIB_SEQ_CTRL_SATURATE_EN selects hold-on-overflow instead of wrap-to-seed.
module fib_step
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] cur,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SEED = WIDTH'(SEQ_SEED);

  logic [WIDTH-1:0] prev;
  logic [WIDTH:0]   sum;

  // ovf flags that the term following cur does not fit in WIDTH bits.
  assign sum = {1'b0, cur} + {1'b0, prev};
  assign ovf = sum[WIDTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur  <= '0;
      prev <= '0;
    end else if (load) begin
      cur  <= SEED;
      prev <= SEED;
    end else if (advance) begin
      if (ovf) begin
`ifdef FIB_SEQ_CTRL_SATURATE_EN
        cur  <= cur;
        prev <= prev;
`else
        cur  <= SEED;
        prev <= SEED;
`endif
      end else begin
        prev <= cur;
        cur  <= sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Start/stop sequencer around fib_step: term counting, output handshake, DONE/OVF pulses.
// Build with FIB_SEQ_CTRL_SATURATE_EN to end the run on overflow instead of wrapping.
module fib_seq_ctrl
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [CNT_W-1:0] NUM_TERMS,
  input  logic             O_READY,
  output logic             O_VALID,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [1:0]       dbg_state
);

  // Handshake: a term transfers on any rising CLK edge where O_VALID and O_READY
  // are both high; while O_VALID is high and O_READY low, O stays unchanged.

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_q;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] o_hold;
  logic             ovf_q;
  logic             step_ovf;
  logic             xfer;
  logic             load;
  logic             last_term;
  logic             ovf_end;

  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (load),
    .advance (xfer),
    .cur     (cur),
    .ovf     (step_ovf)
  );

  assign xfer      = O_VALID & O_READY;
  assign last_term = (num_q != '0) && ((cnt + CNT_W'(1)) == num_q);

`ifdef FIB_SEQ_CTRL_SATURATE_EN
  assign ovf_end = step_ovf;
`else
  assign ovf_end = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && !STOP) begin
          state_nxt = S_RUN;
          load      = 1'b1;
        end
      end
      S_RUN: begin
        // STOP wins over a terminating transfer, so no DONE pulse follows it.
        if (STOP) begin
          state_nxt = S_IDLE;
        end else if (xfer && (last_term || ovf_end)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= '0;
      num_q  <= '0;
      o_hold <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= xfer & step_ovf;
      if (load) begin
        cnt   <= '0;
        num_q <= NUM_TERMS;
      end else if (xfer) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Remember the term on display so O keeps it once the run ends.
      if (state == S_RUN) begin
        o_hold <= cur;
      end
    end
  end

  assign O_VALID   = (state == S_RUN);
  assign BUSY      = (state == S_RUN);
  assign DONE      = (state == S_DONE);
  assign OVF       = ovf_q;
  assign O         = (state == S_RUN) ? cur : o_hold;
  assign dbg_state = state;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl against a periodic-sequence reference model.
// Honours FIB_SEQ_CTRL_SATURATE_EN when the design is built with it.
`timescale 1ns/1ps
module tb_fib_seq_ctrl;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] num_terms = '0;
  logic          o_ready = 1'b0;
  logic          o_valid, busy, done, ovf;
  logic [W-1:0]  o;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  int           cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           exp_ovf_q[$];
  int           ovf_log[$];
  int           done_cnt, done_cyc, first_xfer_cyc, last_xfer_cyc, hold_err;
  bit           timed_out;

  fib_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .STOP      (stop),
    .NUM_TERMS (num_terms),
    .O_READY   (o_ready),
    .O_VALID   (o_valid),
    .O         (o),
    .BUSY      (busy),
    .DONE      (done),
    .OVF       (ovf),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The wrapping sequence is periodic: all Fibonacci terms 1,2,3,5,... that fit in W bits.
  task automatic build_cycle();
    cyc_q.delete();
    cyc_q.push_back(1);
    cyc_q.push_back(2);
    while (cyc_q[cyc_q.size()-1] + cyc_q[cyc_q.size()-2] <= MAXV)
      cyc_q.push_back(cyc_q[cyc_q.size()-1] + cyc_q[cyc_q.size()-2]);
  endtask

  task automatic build_expected(input int num, input int stop_after, output bit exp_done);
    int natural_len;
    int n;
    int len;
    len = cyc_q.size();
    natural_len = (num == 0) ? 1000 : num;
`ifdef FIB_SEQ_CTRL_SATURATE_EN
    if (natural_len > len) natural_len = len;
`endif
    if (stop_after != 0 && stop_after <= natural_len) begin
      n = stop_after;
      exp_done = 1'b0;
    end else begin
      n = natural_len;
      exp_done = 1'b1;
    end
    exp_q.delete();
    exp_ovf_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(W'(cyc_q[k % len]));
      if (k % len == len - 1) exp_ovf_q.push_back(k);
    end
  endtask

  // Drives one run and records what the consumer saw; comparisons live in the tests.
  task automatic drive_run(input int num, input int ready_pct, input int stop_after,
                           input bit start_in_done, input int max_cyc);
    int n_xfer = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_o = '0;
    obs_q.delete();
    ovf_log.delete();
    done_cnt = 0; done_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    hold_err = 0; timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1; stop = 1'b0; num_terms = CW'(num); o_ready = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; num_terms = CW'($urandom_range(0, 255));
      if (ovf) ovf_log.push_back(n_xfer - 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (start_in_done) start = 1'b1;
      end
      if (prev_stall && (!o_valid || o !== prev_o)) hold_err++;
      if (!busy && !done) begin
        timed_out = 1'b0;
        break;
      end
      o_ready = ($urandom_range(0, 99) < ready_pct);
      if (stop_after != 0 && o_valid && n_xfer == stop_after - 1) begin
        o_ready = 1'b1;
        stop = 1'b1;
      end
      prev_stall = o_valid && !o_ready;
      prev_o = o;
      if (o_valid && o_ready) begin
        obs_q.push_back(o);
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_xfer++;
      end
    end
    start = 1'b0; stop = 1'b0; o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_valid, busy, done, ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got v/b/d/o=%b want 0000", {o_valid, busy, done, ovf});
    end
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_o: got %0d want 0", o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_run();
    bit ed;
    int errs = 0;
    drive_run(4, 100, 0, 1'b1, 50);
    build_expected(4, 0, ed);
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out) begin n_fail++; $display("FAIL fixed_seq: got %p want %p", obs_q, exp_q); end
    n_tests++;
    if (done_cnt != int'(ed)) begin n_fail++; $display("FAIL fixed_done_cnt: got %0d want %0d", done_cnt, ed); end
    n_tests++;
    if (first_xfer_cyc != 0 || last_xfer_cyc != exp_q.size() - 1) begin
      n_fail++;
      $display("FAIL fixed_timing: first %0d last %0d want 0 and %0d", first_xfer_cyc, last_xfer_cyc, exp_q.size() - 1);
    end
    n_tests++;
    if (done_cyc != last_xfer_cyc + 1) begin
      n_fail++;
      $display("FAIL fixed_done_lag: done at %0d want %0d", done_cyc, last_xfer_cyc + 1);
    end
    n_tests++;
    if (busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_idle_after: busy %b valid %b want 0 0", busy, o_valid);
    end
  endtask

  task automatic test_continuous_wrap();
    bit ed;
    int errs = 0;
    drive_run(0, 100, 10, 1'b0, 100);
    build_expected(0, 10, ed);
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out) begin n_fail++; $display("FAIL cont_seq: got %p want %p", obs_q, exp_q); end
    errs = 0;
    if (ovf_log.size() != exp_ovf_q.size()) errs++;
    else foreach (exp_ovf_q[i]) if (ovf_log[i] != exp_ovf_q[i]) errs++;
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL cont_ovf: got %p want %p", ovf_log, exp_ovf_q); end
    n_tests++;
    if (done_cnt != int'(ed)) begin n_fail++; $display("FAIL cont_done: got %0d want %0d", done_cnt, ed); end
  endtask

  task automatic test_backpressure();
    bit ed;
    int errs = 0;
    drive_run(12, 40, 0, 1'b0, 400);
    build_expected(12, 0, ed);
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out) begin n_fail++; $display("FAIL bp_seq: got %p want %p", obs_q, exp_q); end
    n_tests++;
    if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err); end
    n_tests++;
    if (done_cnt != int'(ed)) begin n_fail++; $display("FAIL bp_done: got %0d want %0d", done_cnt, ed); end
  endtask

  task automatic test_stop_xfer();
    bit ed;
    int errs = 0;
    drive_run(0, 60, 3, 1'b0, 100);
    build_expected(0, 3, ed);
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out) begin n_fail++; $display("FAIL stop_seq: got %p want %p", obs_q, exp_q); end
    n_tests++;
    if (done_cnt != 0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_end: done %0d valid %b want 0 0", done_cnt, o_valid);
    end
    n_tests++;
    if (o !== exp_q[exp_q.size()-1]) begin
      n_fail++;
      $display("FAIL stop_o_hold: got %0d want %0d", o, exp_q[exp_q.size()-1]);
    end
    // STOP on the very transfer that overflows must still flag OVF.
    drive_run(0, 100, cyc_q.size(), 1'b0, 100);
    build_expected(0, cyc_q.size(), ed);
    errs = 0;
    if (ovf_log.size() != exp_ovf_q.size()) errs++;
    else foreach (exp_ovf_q[i]) if (ovf_log[i] != exp_ovf_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out || done_cnt != 0) begin
      n_fail++;
      $display("FAIL stop_ovf: ovf %p want %p done %0d want 0", ovf_log, exp_ovf_q, done_cnt);
    end
  endtask

  task automatic test_start_stop_idle();
    int bad = 0;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; num_terms = CW'(5);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || o_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL start_stop_idle: %0d busy cycles want 0", bad); end
  endtask

  task automatic test_midrun_reset();
    bit found = 1'b0;
    bit ed;
    int errs = 0;
    @(negedge clk);
    start = 1'b1; num_terms = '0; o_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid && o === W'(8)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!found || {o_valid, busy, done, ovf} !== 4'b0000 || o !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: found8 %b v/b/d/o %b O %0d want 1 0000 0", found, {o_valid, busy, done, ovf}, o);
    end
    o_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_run(3, 100, 0, 1'b0, 50);
    build_expected(3, 0, ed);
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_tests++;
    if (errs != 0 || timed_out) begin n_fail++; $display("FAIL reset_restart: got %p want %p", obs_q, exp_q); end
  endtask

  task automatic test_random_runs();
    bit ed;
    int num, pct, stp, errs;
    for (int r = 0; r < 6; r++) begin
      num = $urandom_range(1, 20);
      pct = $urandom_range(30, 100);
      stp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, num) : 0;
      drive_run(num, pct, stp, 1'b0, 400);
      build_expected(num, stp, ed);
      errs = 0;
      if (obs_q.size() != exp_q.size()) errs++;
      else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
      if (ovf_log.size() != exp_ovf_q.size()) errs++;
      else foreach (exp_ovf_q[i]) if (ovf_log[i] != exp_ovf_q[i]) errs++;
      n_tests++;
      if (errs != 0 || timed_out || done_cnt != int'(ed) || hold_err != 0) begin
        n_fail++;
        $display("FAIL random_run%0d: num %0d stop %0d got %p want %p ovf %p want %p done %0d want %0d hold %0d",
                 r, num, stp, obs_q, exp_q, ovf_log, exp_ovf_q, done_cnt, ed, hold_err);
      end
    end
  endtask

  initial begin
    build_cycle();
    test_reset();
    test_fixed_run();
    test_continuous_wrap();
    test_backpressure();
    test_stop_xfer();
    test_start_stop_idle();
    test_midrun_reset();
    test_random_runs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
